// File: rtl/noc_bus_repeater_pkg.sv
// Shared NOC bus definitions: phit geometry, phit payload struct and byte clean-up helper.
package noc_bus_repeater_pkg;

    localparam int unsigned NOC_PHIT_BYTES = 32;
    localparam int unsigned NOC_BP_W       = 6;
    localparam int unsigned NOC_DAT_W      = NOC_PHIT_BYTES * 8;

    typedef struct packed {
        logic [NOC_PHIT_BYTES-1:0][7:0] dat;
        logic [NOC_BP_W-1:0]            bp;
    } noc_phit_t;

    localparam int unsigned NOC_PHIT_W = $bits(noc_phit_t);

    // Zero every byte at or beyond bp so stale upstream bytes never leak downstream.
    function automatic logic [NOC_PHIT_BYTES-1:0][7:0] clean_bytes(
        input logic [NOC_DAT_W-1:0] dat,
        input logic [NOC_BP_W-1:0]  bp
    );
        logic [NOC_PHIT_BYTES-1:0][7:0] src;
        logic [NOC_PHIT_BYTES-1:0][7:0] res;
        src = dat;
        for (int unsigned i = 0; i < NOC_PHIT_BYTES; i++) begin
            res[i] = (NOC_BP_W'(i) < bp) ? src[i] : 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/noc_bus_repeater_phit_fifo.sv
// DEPTH-entry phit FIFO with modulo-DEPTH pointers; DEPTH need not be a power of two.
module noc_phit_fifo
    import noc_bus_repeater_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  fclk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [NOC_PHIT_W-1:0] wr_phit,
    input  logic                  pop,
    output logic [NOC_PHIT_W-1:0] rd_phit,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [NOC_PHIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_phit = mem[rd_ptr];

    // Occupancy and pointers; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge fclk) begin
        if (do_push) mem[wr_ptr] <= wr_phit;
    end

endmodule

// File: rtl/noc_bus_repeater.sv
// Elastic NOC ring stage: buffers whole phits between NIUs, counts traffic and stalls, flags oversize phits.
module noc_bus_repeater
    import noc_bus_repeater_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 fclk,
    input  logic                 rst_n,
    input  logic [NOC_DAT_W-1:0] bus_inp_dat,
    input  logic [NOC_BP_W-1:0]  bus_inp_bp,
    output logic                 bus_inp_bo,
    output logic [NOC_DAT_W-1:0] bus_oup_dat,
    output logic [NOC_BP_W-1:0]  bus_oup_bp,
    input  logic                 bus_oup_bo,
    input  logic                 stat_clr,
    output logic [CNT_W-1:0]     stat_phits,
    output logic [CNT_W-1:0]     stat_bytes,
    output logic [CNT_W-1:0]     stat_stall,
    output logic                 err_bp
);

    if (DEPTH < 2) begin : g_depth_chk
        $error("noc_bus_repeater: DEPTH must be at least 2");
    end

    noc_phit_t             in_phit;
    noc_phit_t             head;
    logic [NOC_PHIT_W-1:0] rd_flat;
    logic                  full;
    logic                  empty;
    logic                  up_xfer;
    logic                  bad_bp;
    logic                  do_push;
    logic                  dn_xfer;
    logic                  stall;
    logic [CNT_W-1:0]      phits_q;
    logic [CNT_W-1:0]      bytes_q;
    logic [CNT_W-1:0]      stall_q;
    logic                  err_q;

    // Upstream side: bus open depends only on registered occupancy.
    assign bus_inp_bo = !full;
    assign up_xfer    = (bus_inp_bp != '0) && bus_inp_bo;
    assign bad_bp     = (bus_inp_bp > NOC_BP_W'(NOC_PHIT_BYTES));
    assign do_push    = up_xfer && !bad_bp;

    always_comb begin
        in_phit.bp  = bus_inp_bp;
        in_phit.dat = clean_bytes(bus_inp_dat, bus_inp_bp);
    end

    noc_phit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .fclk    (fclk),
        .rst_n   (rst_n),
        .push    (do_push),
        .wr_phit (in_phit),
        .pop     (dn_xfer),
        .rd_phit (rd_flat),
        .full    (full),
        .empty   (empty)
    );

    // Downstream side: present the head only when something is buffered.
    always_comb begin
        head        = noc_phit_t'(rd_flat);
        bus_oup_bp  = empty ? '0 : head.bp;
        bus_oup_dat = empty ? '0 : head.dat;
    end

    assign dn_xfer = !empty && bus_oup_bo;
    assign stall   = !empty && !bus_oup_bo;

    // Performance counters and sticky error; clear wins over any increment.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            phits_q <= '0;
            bytes_q <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else if (stat_clr) begin
            phits_q <= '0;
            bytes_q <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (dn_xfer) begin
                phits_q <= phits_q + CNT_W'(1);
                bytes_q <= bytes_q + CNT_W'(head.bp);
            end
            if (stall)              stall_q <= stall_q + CNT_W'(1);
            if (up_xfer && bad_bp)  err_q   <= 1'b1;
        end
    end

    assign stat_phits = phits_q;
    assign stat_bytes = bytes_q;
    assign stat_stall = stall_q;
    assign err_bp     = err_q;

endmodule

// File: tb/tb_noc_bus_repeater.sv
// Scoreboard bench for noc_bus_repeater: expected phits queued on upstream transfer, checked on downstream transfer.
module tb_noc_bus_repeater;
    import noc_bus_repeater_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 32;

    logic             fclk = 1'b0;
    logic             rst_n;
    logic [255:0]     bus_inp_dat;
    logic [5:0]       bus_inp_bp;
    logic             bus_inp_bo;
    logic [255:0]     bus_oup_dat;
    logic [5:0]       bus_oup_bp;
    logic             bus_oup_bo;
    logic             stat_clr;
    logic [CNT_W-1:0] stat_phits;
    logic [CNT_W-1:0] stat_bytes;
    logic [CNT_W-1:0] stat_stall;
    logic             err_bp;

    typedef struct packed {
        logic [255:0] dat;
        logic [5:0]   bp;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   mon_en       = 1'b0;

    noc_bus_repeater #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .fclk        (fclk),
        .rst_n       (rst_n),
        .bus_inp_dat (bus_inp_dat),
        .bus_inp_bp  (bus_inp_bp),
        .bus_inp_bo  (bus_inp_bo),
        .bus_oup_dat (bus_oup_dat),
        .bus_oup_bp  (bus_oup_bp),
        .bus_oup_bo  (bus_oup_bo),
        .stat_clr    (stat_clr),
        .stat_phits  (stat_phits),
        .stat_bytes  (stat_bytes),
        .stat_stall  (stat_stall),
        .err_bp      (err_bp)
    );

    always #5 fclk = ~fclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Downstream monitor: every transfer must match the oldest expected phit.
    always @(negedge fclk) begin
        exp_t e;
        if (mon_en && rst_n && bus_oup_bp != 6'd0 && bus_oup_bo) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got bp=%0d, expected no phit", bus_oup_bp);
            end else begin
                e = sb.pop_front();
                if (bus_oup_bp !== e.bp || bus_oup_dat !== e.dat) begin
                    tests_failed++;
                    $display("FAIL sb_phit: got bp=%0d dat=%h, expected bp=%0d dat=%h",
                             bus_oup_bp, bus_oup_dat, e.bp, e.dat);
                end
            end
        end
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] mask_bytes(input logic [255:0] raw, input int bp);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) if (i < bp) r[i*8 +: 8] = raw[i*8 +: 8];
        return r;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge fclk);
        #1;
    endtask

    task automatic idle();
        bus_inp_bp  = 6'd0;
        bus_inp_dat = rnd256();
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        cycles(1);
        stat_clr = 1'b0;
    endtask

    // Offer one phit and hold it until accepted; returns at posedge+1 after capture.
    task automatic send_phit(input logic [5:0] bp, input logic [255:0] raw, output int waits);
        exp_t e;
        bus_inp_bp  = bp;
        bus_inp_dat = raw;
        waits = 0;
        @(negedge fclk);
        while (!bus_inp_bo && waits < 200) begin
            waits++;
            @(negedge fclk);
        end
        if (!bus_inp_bo) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: bus_inp_bo=%0b after %0d cycles, expected 1", bus_inp_bo, waits);
        end else if (bp <= 6'd32) begin
            e.dat = mask_bytes(raw, int'(bp));
            e.bp  = bp;
            sb.push_back(e);
        end
        @(posedge fclk);
        #1;
    endtask

    task automatic test_reset();
        int w;
        #3;
        tests_run += 4;
        if (bus_oup_bp !== 6'd0) begin tests_failed++; $display("FAIL rst_oup_bp: got %0d, expected 0", bus_oup_bp); end
        if (bus_inp_bo !== 1'b1) begin tests_failed++; $display("FAIL rst_inp_bo: got %0b, expected 1", bus_inp_bo); end
        if (stat_phits !== 0 || stat_bytes !== 0 || stat_stall !== 0) begin
            tests_failed++; $display("FAIL rst_counters: got %0d/%0d/%0d, expected 0/0/0", stat_phits, stat_bytes, stat_stall);
        end
        if (err_bp !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %0b, expected 0", err_bp); end
        @(negedge fclk);
        rst_n = 1'b1;
        cycles(1);
        mon_en = 1'b1;
        // Fill the buffer, hold a third phit upstream, then reset mid-burst.
        bus_oup_bo = 1'b0;
        send_phit(6'd9, rnd256(), w);
        send_phit(6'd20, rnd256(), w);
        bus_inp_bp  = 6'd3;
        bus_inp_dat = rnd256();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run += 3;
        if (bus_oup_bp !== 6'd0 || bus_oup_dat !== '0) begin
            tests_failed++; $display("FAIL rst_mid_oup: got bp=%0d, expected bp=0 dat=0", bus_oup_bp);
        end
        if (bus_inp_bo !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_inp_bo: got %0b, expected 1", bus_inp_bo); end
        if (stat_stall !== 0) begin tests_failed++; $display("FAIL rst_mid_stall: got %0d, expected 0", stat_stall); end
        sb.delete();
        idle();
        bus_oup_bo = 1'b1;
        @(negedge fclk);
        rst_n = 1'b1;
        cycles(3);
        tests_run++;
        if (bus_oup_bp !== 6'd0 || stat_phits !== 0) begin
            tests_failed++; $display("FAIL rst_stale: got bp=%0d phits=%0d, expected 0/0", bus_oup_bp, stat_phits);
        end
    endtask

    task automatic test_single();
        int w;
        logic [255:0] raw;
        logic [255:0] hi;
        clear_stats();
        bus_oup_bo = 1'b1;
        raw = rnd256();
        send_phit(6'd5, raw, w);
        idle();
        hi = bus_oup_dat >> 40;
        tests_run += 3;
        if (bus_oup_bp !== 6'd5) begin tests_failed++; $display("FAIL single_bp: got %0d, expected 5", bus_oup_bp); end
        if (bus_oup_dat !== mask_bytes(raw, 5)) begin
            tests_failed++; $display("FAIL single_dat: got %h, expected %h", bus_oup_dat, mask_bytes(raw, 5));
        end
        if (hi !== '0) begin tests_failed++; $display("FAIL single_upper: got %h, expected 0", hi); end
        cycles(2);
        tests_run += 2;
        if (stat_phits !== 1 || stat_bytes !== 5) begin
            tests_failed++; $display("FAIL single_stats: got phits=%0d bytes=%0d, expected 1/5", stat_phits, stat_bytes);
        end
        if (sb.size() != 0) begin tests_failed++; $display("FAIL single_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int w;
        logic [255:0] raw_c;
        clear_stats();
        bus_oup_bo = 1'b0;
        send_phit(6'd12, rnd256(), w);
        send_phit(6'd32, rnd256(), w);
        tests_run++;
        if (bus_inp_bo !== 1'b0) begin tests_failed++; $display("FAIL bp_full: got bo=%0b, expected 0", bus_inp_bo); end
        raw_c = rnd256();
        bus_inp_bp  = 6'd7;
        bus_inp_dat = raw_c;
        cycles(5);
        tests_run += 2;
        if (stat_stall !== 6) begin tests_failed++; $display("FAIL bp_stall: got %0d, expected 6", stat_stall); end
        if (bus_inp_bo !== 1'b0) begin tests_failed++; $display("FAIL bp_held: got bo=%0b, expected 0", bus_inp_bo); end
        bus_oup_bo = 1'b1;
        send_phit(6'd7, raw_c, w);
        idle();
        tests_run++;
        if (w != 1) begin tests_failed++; $display("FAIL bp_release_wait: got %0d, expected 1", w); end
        cycles(4);
        tests_run += 2;
        if (sb.size() != 0) begin tests_failed++; $display("FAIL bp_drain: got %0d pending, expected 0", sb.size()); end
        if (stat_phits !== 3 || stat_bytes !== 51 || stat_stall !== 6) begin
            tests_failed++;
            $display("FAIL bp_stats: got %0d/%0d/%0d, expected 3/51/6", stat_phits, stat_bytes, stat_stall);
        end
    endtask

    task automatic test_streaming();
        int w;
        int total_w = 0;
        clear_stats();
        bus_oup_bo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send_phit(6'd32, rnd256(), w);
            total_w += w;
        end
        idle();
        cycles(3);
        tests_run += 3;
        if (total_w != 0) begin tests_failed++; $display("FAIL stream_bubbles: got %0d, expected 0", total_w); end
        if (stat_phits !== 100 || stat_bytes !== 3200 || stat_stall !== 0) begin
            tests_failed++;
            $display("FAIL stream_stats: got %0d/%0d/%0d, expected 100/3200/0", stat_phits, stat_bytes, stat_stall);
        end
        if (sb.size() != 0) begin tests_failed++; $display("FAIL stream_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_full_pop();
        int w;
        clear_stats();
        bus_oup_bo = 1'b0;
        send_phit(6'd1, rnd256(), w);
        send_phit(6'd17, rnd256(), w);
        idle();
        bus_oup_bo = 1'b1;
        #1;
        tests_run++;
        if (bus_inp_bo !== 1'b0) begin tests_failed++; $display("FAIL fullpop_same: got bo=%0b, expected 0", bus_inp_bo); end
        cycles(1);
        tests_run++;
        if (bus_inp_bo !== 1'b1) begin tests_failed++; $display("FAIL fullpop_next: got bo=%0b, expected 1", bus_inp_bo); end
        cycles(3);
        tests_run++;
        if (sb.size() != 0) begin tests_failed++; $display("FAIL fullpop_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_clr_priority();
        int w;
        clear_stats();
        bus_oup_bo = 1'b0;
        send_phit(6'd4, rnd256(), w);
        idle();
        cycles(2);
        clear_stats();
        tests_run++;
        if (stat_stall !== 0) begin tests_failed++; $display("FAIL clr_priority: got %0d, expected 0", stat_stall); end
        cycles(1);
        tests_run++;
        if (stat_stall !== 1) begin tests_failed++; $display("FAIL clr_resume: got %0d, expected 1", stat_stall); end
        bus_oup_bo = 1'b1;
        cycles(3);
    endtask

    task automatic test_malformed();
        int w;
        clear_stats();
        bus_oup_bo = 1'b1;
        send_phit(6'd40, rnd256(), w);
        idle();
        cycles(3);
        tests_run += 2;
        if (err_bp !== 1'b1) begin tests_failed++; $display("FAIL bad_err_set: got %0b, expected 1", err_bp); end
        if (stat_phits !== 0 || stat_bytes !== 0) begin
            tests_failed++; $display("FAIL bad_dropped: got %0d/%0d, expected 0/0", stat_phits, stat_bytes);
        end
        send_phit(6'd7, rnd256(), w);
        idle();
        cycles(3);
        tests_run += 2;
        if (err_bp !== 1'b1) begin tests_failed++; $display("FAIL bad_err_held: got %0b, expected 1", err_bp); end
        if (stat_phits !== 1 || stat_bytes !== 7) begin
            tests_failed++; $display("FAIL bad_next_ok: got %0d/%0d, expected 1/7", stat_phits, stat_bytes);
        end
        clear_stats();
        tests_run++;
        if (err_bp !== 1'b0 || stat_phits !== 0 || stat_bytes !== 0 || stat_stall !== 0) begin
            tests_failed++;
            $display("FAIL bad_clr: got err=%0b %0d/%0d/%0d, expected 0 0/0/0", err_bp, stat_phits, stat_bytes, stat_stall);
        end
    endtask

    task automatic test_back_to_back();
        int  sum = 0;
        bit  done = 1'b0;
        clear_stats();
        fork
            begin
                int w;
                int bp;
                for (int i = 0; i < 40; i++) begin
                    bp = $urandom_range(1, 32);
                    sum += bp;
                    send_phit(6'(bp), rnd256(), w);
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus_oup_bo = 1'($urandom_range(0, 1));
                    cycles(1);
                end
            end
        join
        bus_oup_bo = 1'b1;
        cycles(4);
        tests_run += 2;
        if (stat_phits !== 40 || stat_bytes !== sum) begin
            tests_failed++; $display("FAIL b2b_stats: got %0d/%0d, expected 40/%0d", stat_phits, stat_bytes, sum);
        end
        if (sb.size() != 0) begin tests_failed++; $display("FAIL b2b_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus_inp_dat = '0;
        bus_inp_bp  = 6'd0;
        bus_oup_bo  = 1'b1;
        stat_clr    = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_full_pop();
        test_clr_priority();
        test_malformed();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
